truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer that exhaustively exercises the 4-variable expression block (outputs f,g,h).
//  On start, drives all 16 {A,B,C,D} combinations in ascending order, samples f/g/h after a
//  settle window and packs them into 16-bit truth tables. Compares the tables to golden
//  constants and reports pass / first failing index. Sits between board/test control and the
//  combinational expression block.
// PARAMETERS
//  SETTLE_CYCLES  1         cycles each combination is held before sampling (>=1)
//  EXP_F          16'hFFFE  golden f table (any variable 1)
//  EXP_G          16'h8000  golden g table (all variables 1)
//  EXP_H          16'hE997  golden h table (0 iff exactly two variables are 1)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  start        in   1   sweep request, sampled only in IDLE
//  busy         out  1   high while the sweep is in progress
//  done         out  1   one-cycle pulse when the sweep completes
//  A,B,C,D      out  1   stimulus to the expression block; index k = {A,B,C,D}, A = MSB
//  f,g,h        in   1   responses from the expression block
//  tt_f,tt_g,tt_h out 16 captured truth tables; bit k = response for combination k
//  pass         out  1   1 = all three tables match their goldens; valid from done, held
//  fail_idx     out  4   lowest k with any mismatch; 0 when pass=1
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, busy=0, done=0, A..D=0, tt_*=0,
//    pass=0, fail_idx=0, internal index/settle counters=0.
//  - FSM: IDLE -> DRIVE (on start) ; DRIVE -> SAMPLE after SETTLE_CYCLES cycles ;
//    SAMPLE -> DRIVE (k<15, k++) | DONE (k==15) ; DONE -> IDLE after exactly 1 cycle.
//  - On start acceptance: k=0, tt_*=0, fail_found=0, fail_idx=0, pass=0.
//  - A..D = k, registered; stable for the whole DRIVE+SAMPLE window of combination k.
//  - SAMPLE edge: tt_f[k]<=f, tt_g[k]<=g, tt_h[k]<=h; if any mismatch vs EXP_*[k] and no
//    earlier fail recorded, fail_idx<=k and fail_found<=1.
//  - Entering DONE: pass <= ~fail_found (incl. k=15 sample); done=1 for that single cycle.
//  - Timing: each combination takes SETTLE_CYCLES+1 cycles; done is high in the cycle
//    after edge 16*(SETTLE_CYCLES+1) counted from the start-accept edge (S=1 -> 32).
//  - busy=1 in DRIVE and SAMPLE only; 0 in IDLE and DONE.
//  - start while busy or in DONE: ignored, no effect on sequence or results.
//  - start held high continuously: a new sweep starts from the IDLE cycle after DONE.
//  - After done: A..D return to 0 in IDLE; tt_*, pass, fail_idx hold until next accept.
//  - rst_n low mid-sweep: immediate return to reset values; no done pulse; partial
//    results discarded.
//  - k is 4 bits; increment from 15 never occurs (DONE taken instead); no wrap.
// STRUCTURE
//  - Shared package tt_sweep_pkg: state encoding (IDLE, DRIVE, SAMPLE, DONE), N_COMB=16,
//    default golden constants EXP_F/EXP_G/EXP_H.
//  - Settle counter width $clog2(SETTLE_CYCLES+1); reloads on every DRIVE entry.
//  - Single module; no sub-module needed. Bench instantiates sweeper + expression block.
// TESTING
//  1. rst_n=0 -> busy=0, done=0, A..D=0, tt_f/g/h=0000, pass=0, fail_idx=0.
//  2. start pulse, correct block, S=1 -> busy 32 cycles, one done pulse, tt_f=FFFE,
//     tt_g=8000, tt_h=E997, pass=1, fail_idx=0.
//  3. Fault: g forced 0 -> tt_g=0000, pass=0, fail_idx=15; f forced 1 -> tt_f=FFFF,
//     fail_idx=0; h inverted -> fail_idx=0.
//  4. start re-pulsed at cycles 5 and 20 of a sweep -> ignored; exactly one done at 32.
//  5. rst_n=0 while A..D=7 -> outputs reset same cycle, no done; release + start ->
//     clean full sweep, pass=1.
//  6. SETTLE_CYCLES=3 -> each combination held 4 cycles, done after 64; results as test 2.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared state encoding and golden truth tables for the sweeper
package tt_sweep_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
   localparam int N_COMB = 16;
   localparam logic [15:0] EXP_F_DEF = 16'hFFFE;
   localparam logic [15:0] EXP_G_DEF = 16'h8000;
   localparam logic [15:0] EXP_H_DEF = 16'hE997;
endpackage

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {A,B,C,D} combinations, captures f/g/h truth tables, checks them
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter logic [15:0] EXP_F = EXP_F_DEF,
   parameter logic [15:0] EXP_G = EXP_G_DEF,
   parameter logic [15:0] EXP_H = EXP_H_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   input  logic        f,
   input  logic        g,
   input  logic        h,
   output logic [15:0] tt_f,
   output logic [15:0] tt_g,
   output logic [15:0] tt_h,
   output logic        pass,
   output logic [3:0]  fail_idx
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYCLES - 1);
   localparam logic [3:0] LAST_K = 4'(N_COMB - 1);

   state_t state, state_next;
   logic [3:0] k;
   logic [CW-1:0] cnt;
   logic fail_found;
   logic mis;

   assign {A, B, C, D} = k;
   assign mis = (f != EXP_F[k]) | (g != EXP_G[k]) | (h != EXP_H[k]);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   end

   // next-state and status decode
   always_comb begin
      busy = (state == DRIVE) || (state == SAMPLE);
      done = (state == DONE);
      state_next = (state == IDLE)   ? (start ? DRIVE : IDLE) :
                   (state == DRIVE)  ? ((cnt == LAST_SETTLE) ? SAMPLE : DRIVE) :
                   (state == SAMPLE) ? ((k == LAST_K) ? DONE : DRIVE) :
                                       IDLE;
   end

   // index, settle counter, truth-table capture and pass/fail bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k <= '0;
         cnt <= '0;
         tt_f <= '0;
         tt_g <= '0;
         tt_h <= '0;
         pass <= 1'b0;
         fail_idx <= '0;
         fail_found <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               k <= '0;
               cnt <= '0;
               tt_f <= '0;
               tt_g <= '0;
               tt_h <= '0;
               pass <= 1'b0;
               fail_idx <= '0;
               fail_found <= 1'b0;
            end
            DRIVE: cnt <= cnt + 1'b1;
            SAMPLE: begin
               tt_f[k] <= f;
               tt_g[k] <= g;
               tt_h[k] <= h;
               if (mis && !fail_found) begin
                  fail_idx <= k;
                  fail_found <= 1'b1;
               end
               if (k == LAST_K) pass <= ~(fail_found | mis);
               else begin
                  k <= k + 1'b1;
                  cnt <= '0;
               end
            end
            default: k <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of the sweeper against a behavioural expression block
module tb_truth_table_sweeper;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0, start3 = 1'b0;
   logic busy1, done1, a1, b1, c1, d1, f1, g1, h1, pass1;
   logic busy3, done3, a3, b3, c3, d3, f3, g3, h3, pass3;
   logic [15:0] ttf1, ttg1, tth1, ttf3, ttg3, tth3;
   logic [3:0] fidx1, fidx3, v1, v3;
   int mode = 0;
   int n_checks = 0;
   int n_fail = 0;
   int busy_n, done_n, done_first, done_last, first1;
   bit seen_done;

   always #5 clk = ~clk;

   assign v1 = {a1, b1, c1, d1};
   assign v3 = {a3, b3, c3, d3};
   assign f1 = (mode == 2) ? 1'b1 : |v1;
   assign g1 = (mode == 1) ? 1'b0 : &v1;
   assign h1 = ($countones(v1) != 2) ^ (mode == 3);
   assign f3 = |v3;
   assign g3 = &v3;
   assign h3 = $countones(v3) != 2;

   truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .A(a1), .B(b1), .C(c1), .D(d1), .f(f1), .g(g1), .h(h1),
      .tt_f(ttf1), .tt_g(ttg1), .tt_h(tth1), .pass(pass1), .fail_idx(fidx1)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
      .A(a3), .B(b3), .C(c3), .D(d3), .f(f3), .g(g3), .h(h3),
      .tt_f(ttf3), .tt_g(ttg3), .tt_h(tth3), .pass(pass3), .fail_idx(fidx3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // cycle c is the negedge sample taken after edge c-1, edge 0 being the start-accept edge
   task automatic sweep(input bit sel, input bit repulse, input bit hold);
      busy_n = 0; done_n = 0; done_first = 0; done_last = 0; first1 = 0;
      @(negedge clk);
      if (sel) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
      for (int c = 1; c <= 200; c++) begin
         if (sel ? busy3 : busy1) busy_n++;
         if (sel ? done3 : done1) begin
            done_n++;
            if (done_first == 0) done_first = c;
            done_last = c;
         end
         if (first1 == 0 && (sel ? v3 : v1) == 4'd1) first1 = c;
         if (repulse) start1 = (c == 5) || (c == 20);
         if (done_first != 0 && c >= done_first + (hold ? 40 : 3)) break;
         @(negedge clk);
      end
      start1 = 1'b0; start3 = 1'b0;
      for (int c = 0; c < 200 && (busy1 || done1 || busy3 || done3); c++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_results1(input string tag, input logic [15:0] ef, input logic [15:0] eg,
                                 input logic [15:0] eh, input logic ep, input logic [3:0] ei);
      check({tag, " tt_f"}, ttf1, ef);
      check({tag, " tt_g"}, ttg1, eg);
      check({tag, " tt_h"}, tth1, eh);
      check({tag, " pass"}, pass1, ep);
      check({tag, " fail_idx"}, fidx1, ei);
   endtask

   initial begin
      #12;
      check("rst busy", busy1, 0);
      check("rst done", done1, 0);
      check("rst abcd", v1, 0);
      check("rst tt_f", ttf1, 0);
      check("rst tt_g", ttg1, 0);
      check("rst tt_h", tth1, 0);
      check("rst pass", pass1, 0);
      check("rst fail_idx", fidx1, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      sweep(0, 0, 0);
      check("s1 busy cycles", busy_n, 32);
      check("s1 done count", done_n, 1);
      check("s1 done cycle", done_first, 33);
      check("s1 first k=1 cycle", first1, 3);
      check("s1 idle abcd", v1, 0);
      check_results1("s1", 16'hFFFE, 16'h8000, 16'hE997, 1'b1, 4'd0);

      mode = 1;
      sweep(0, 0, 0);
      check_results1("g0", 16'hFFFE, 16'h0000, 16'hE997, 1'b0, 4'd15);
      mode = 2;
      sweep(0, 0, 0);
      check_results1("f1", 16'hFFFF, 16'h8000, 16'hE997, 1'b0, 4'd0);
      mode = 3;
      sweep(0, 0, 0);
      check_results1("hinv", 16'hFFFE, 16'h8000, 16'h1668, 1'b0, 4'd0);
      mode = 0;

      sweep(0, 1, 0);
      check("repulse busy cycles", busy_n, 32);
      check("repulse done count", done_n, 1);
      check("repulse done cycle", done_first, 33);
      check_results1("repulse", 16'hFFFE, 16'h8000, 16'hE997, 1'b1, 4'd0);

      sweep(0, 0, 1);
      check("hold done count", done_n, 2);
      check("hold first done", done_first, 33);
      check("hold second done", done_last, 67);

      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int c = 0; c < 100 && v1 != 4'd7; c++) @(negedge clk);
      check("pre-reset abcd", v1, 7);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst busy", busy1, 0);
      check("mid rst abcd", v1, 0);
      check("mid rst tt_f", ttf1, 0);
      check("mid rst tt_h", tth1, 0);
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done1) seen_done = 1'b1;
      end
      check("mid rst no done", seen_done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      sweep(0, 0, 0);
      check("post rst done cycle", done_first, 33);
      check_results1("post rst", 16'hFFFE, 16'h8000, 16'hE997, 1'b1, 4'd0);

      sweep(1, 0, 0);
      check("s3 busy cycles", busy_n, 64);
      check("s3 done count", done_n, 1);
      check("s3 done cycle", done_first, 65);
      check("s3 first k=1 cycle", first1, 5);
      check("s3 tt_f", ttf3, 16'hFFFE);
      check("s3 tt_g", ttg3, 16'h8000);
      check("s3 tt_h", tth3, 16'hE997);
      check("s3 pass", pass3, 1);
      check("s3 fail_idx", fidx3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
